// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM state encoding and alignment helper for the memory-access stage.
package mem_stage_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned RegWidth  = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPass = 2'd1,
    StMem  = 2'd2
  } mem_state_e;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_exmem_reg.sv
// EX/MEM pipeline latch: captures the whole EX payload when load_i is high, holds otherwise.
module exmem_reg
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DataWidth,
  parameter int unsigned ADDR_W = AddrWidth,
  parameter int unsigned REG_W  = RegWidth
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              branch_i,
  input  logic              mem_read_i,
  input  logic              mem_to_reg_i,
  input  logic              mem_write_i,
  input  logic              reg_write_i,
  input  logic              alu_zero_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] rdata2_i,
  input  logic [REG_W-1:0]  reg_dst_i,
  output logic              branch_o,
  output logic              mem_read_o,
  output logic              mem_to_reg_o,
  output logic              mem_write_o,
  output logic              reg_write_o,
  output logic              alu_zero_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [REG_W-1:0]  reg_dst_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_o     <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_to_reg_o <= 1'b0;
      mem_write_o  <= 1'b0;
      reg_write_o  <= 1'b0;
      alu_zero_o   <= 1'b0;
      pc_o         <= '0;
      alu_result_o <= '0;
      rdata2_o     <= '0;
      reg_dst_o    <= '0;
    end else if (load_i) begin
      branch_o     <= branch_i;
      mem_read_o   <= mem_read_i;
      mem_to_reg_o <= mem_to_reg_i;
      mem_write_o  <= mem_write_i;
      reg_write_o  <= reg_write_i;
      alu_zero_o   <= alu_zero_i;
      pc_o         <= pc_i;
      alu_result_o <= alu_result_i;
      rdata2_o     <= rdata2_i;
      reg_dst_o    <= reg_dst_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM latch, branch redirect, load/store handshake
// with the data memory and a registered write-back interface.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DataWidth,
  parameter int unsigned ADDR_W = AddrWidth,
  parameter int unsigned REG_W  = RegWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_Branch,
  input  logic              ex_MemRead,
  input  logic              ex_MemtoReg,
  input  logic              ex_MemWrite,
  input  logic              ex_RegWrite,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ALUZero,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ex_rdata2,
  input  logic [REG_W-1:0]  reg_dst,
  output logic              pc_src,
  output logic [ADDR_W-1:0] branch_target,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [REG_W-1:0]  wb_reg_dst,
  output logic              wb_excp
);

  mem_state_e state_q, state_d;

  logic              accept;
  logic              new_access;
  logic              complete;
  logic              lat_fault;

  logic              l_branch;
  logic              l_mem_read;
  logic              l_mem_to_reg;
  logic              l_mem_write;
  logic              l_reg_write;
  logic              l_alu_zero;
  logic [ADDR_W-1:0] l_pc;
  logic [DATA_W-1:0] l_alu_result;
  logic [DATA_W-1:0] l_rdata2;
  logic [REG_W-1:0]  l_reg_dst;

  exmem_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_exmem_reg (
    .clk_i        (clk),
    .rst_ni       (rst),
    .load_i       (accept),
    .branch_i     (ex_Branch),
    .mem_read_i   (ex_MemRead),
    .mem_to_reg_i (ex_MemtoReg),
    .mem_write_i  (ex_MemWrite),
    .reg_write_i  (ex_RegWrite),
    .alu_zero_i   (ALUZero),
    .pc_i         (ex_pc),
    .alu_result_i (ALUResult),
    .rdata2_i     (ex_rdata2),
    .reg_dst_i    (reg_dst),
    .branch_o     (l_branch),
    .mem_read_o   (l_mem_read),
    .mem_to_reg_o (l_mem_to_reg),
    .mem_write_o  (l_mem_write),
    .reg_write_o  (l_reg_write),
    .alu_zero_o   (l_alu_zero),
    .pc_o         (l_pc),
    .alu_result_o (l_alu_result),
    .rdata2_o     (l_rdata2),
    .reg_dst_o    (l_reg_dst)
  );

  // Handshake: only an outstanding access stalls EX; its ack frees the slot on the same edge.
  always_comb begin
    ex_ready   = (state_q != StMem) | dm_ack;
    accept     = ex_valid & ex_ready;
    new_access = (ex_MemRead | ex_MemWrite) & word_aligned(ALUResult[1:0]);
    lat_fault  = (l_mem_read | l_mem_write) & ~word_aligned(l_alu_result[1:0]);
    complete   = (state_q == StPass) | ((state_q == StMem) & dm_ack);
  end

  always_comb begin
    state_d = StIdle;
    if (accept) begin
      state_d = new_access ? StMem : StPass;
    end else if ((state_q == StMem) && !dm_ack) begin
      state_d = StMem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      wb_valid      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_MemtoReg   <= 1'b0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_reg_dst    <= '0;
      wb_excp       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (complete) begin
        wb_valid      <= 1'b1;
        // A faulted access must never update the register file.
        wb_RegWrite   <= l_reg_write & ~lat_fault;
        wb_MemtoReg   <= l_mem_to_reg;
        wb_alu_result <= l_alu_result;
        wb_mem_data   <= ((state_q == StMem) && l_mem_read) ? dm_rdata : '0;
        wb_reg_dst    <= l_reg_dst;
        wb_excp       <= lat_fault;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    dm_req        = (state_q == StMem);
    dm_we         = l_mem_write;
    dm_addr       = ADDR_W'(l_alu_result);
    dm_wdata      = l_rdata2;
    pc_src        = (state_q == StPass) & l_branch & l_alu_zero;
    branch_target = l_pc;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model plus directed scenarios.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic        ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite;
  logic [31:0] ex_pc;
  logic        ALUZero;
  logic [31:0] ALUResult, ex_rdata2;
  logic [4:0]  reg_dst;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid, wb_RegWrite, wb_MemtoReg, wb_excp;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic [4:0]  wb_reg_dst;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_Branch     (ex_Branch),
    .ex_MemRead    (ex_MemRead),
    .ex_MemtoReg   (ex_MemtoReg),
    .ex_MemWrite   (ex_MemWrite),
    .ex_RegWrite   (ex_RegWrite),
    .ex_pc         (ex_pc),
    .ALUZero       (ALUZero),
    .ALUResult     (ALUResult),
    .ex_rdata2     (ex_rdata2),
    .reg_dst       (reg_dst),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .wb_valid      (wb_valid),
    .wb_RegWrite   (wb_RegWrite),
    .wb_MemtoReg   (wb_MemtoReg),
    .wb_alu_result (wb_alu_result),
    .wb_mem_data   (wb_mem_data),
    .wb_reg_dst    (wb_reg_dst),
    .wb_excp       (wb_excp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        branch, mread, m2r, mwrite, rwrite, zero;
    logic [31:0] pc, res, wdata;
    logic [4:0]  rd;
  } op_t;

  typedef struct packed {
    logic        valid, rwrite, m2r, excp;
    logic [31:0] alu, mem;
    logic [4:0]  rd;
  } wb_t;

  typedef struct packed {
    int unsigned delay;
    logic [31:0] rdata;
  } acc_t;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_mem(input op_t o);
    return o.mread || o.mwrite;
  endfunction

  function automatic logic is_access(input op_t o);
    return is_mem(o) && (o.res % 4 == 0);
  endfunction

  // ---------------- memory responder ----------------
  acc_t        acc_q[$];
  int unsigned ack_cnt = 0;
  logic        acked = 1'b0;
  logic        stray_ack = 1'b0;

  always @(posedge clk) begin
    #2;
    if (acked) begin
      if (acc_q.size() > 0) void'(acc_q.pop_front());
      acked   = 1'b0;
      ack_cnt = 0;
    end
    if (dm_req && acc_q.size() > 0) begin
      ack_cnt++;
      if (ack_cnt >= acc_q[0].delay) begin
        dm_ack   = 1'b1;
        dm_rdata = acc_q[0].rdata;
        acked    = 1'b1;
      end else begin
        dm_ack = 1'b0;
      end
    end else begin
      ack_cnt = 0;
      dm_ack  = stray_ack;
    end
  end

  // ---------------- model and compare ----------------
  op_t  held;
  logic held_valid, waiting;
  wb_t  m_wb;

  int          n_req, n_ready_low, n_pc, n_wb, run, max_run;
  logic [31:0] last_alu, last_mem, last_wdata, last_target;
  logic [4:0]  last_rd;
  logic        last_m2r, last_rwrite, last_excp, last_we;

  task automatic clear_stats();
    n_req = 0; n_ready_low = 0; n_pc = 0; n_wb = 0; run = 0; max_run = 0;
  endtask

  always @(negedge clk) begin
    logic exp_ready, exp_pc, done;
    op_t  cur;
    if (!rst) begin
      held_valid = 1'b0;
      waiting    = 1'b0;
      held       = '0;
      m_wb       = '0;
    end
    exp_ready = !waiting || dm_ack;
    exp_pc    = held_valid && !waiting && held.branch && held.zero;
    check("ex_ready", ex_ready, exp_ready);
    check("dm_req", dm_req, waiting);
    if (waiting) begin
      check("dm_we", dm_we, held.mwrite);
      check("dm_addr", dm_addr, held.res);
      check("dm_wdata", dm_wdata, held.wdata);
    end
    check("pc_src", pc_src, exp_pc);
    if (exp_pc) check("branch_target", branch_target, held.pc);
    check("wb_valid", wb_valid, m_wb.valid);
    check("wb_RegWrite", wb_RegWrite, m_wb.rwrite);
    check("wb_MemtoReg", wb_MemtoReg, m_wb.m2r);
    check("wb_alu_result", wb_alu_result, m_wb.alu);
    check("wb_mem_data", wb_mem_data, m_wb.mem);
    check("wb_reg_dst", wb_reg_dst, m_wb.rd);
    check("wb_excp", wb_excp, m_wb.excp);

    if (dm_req) begin n_req++; last_we = dm_we; last_wdata = dm_wdata; end
    if (!ex_ready) n_ready_low++;
    if (pc_src) begin n_pc++; last_target = branch_target; end
    if (wb_valid) begin
      n_wb++; run++;
      if (run > max_run) max_run = run;
      last_alu = wb_alu_result; last_mem = wb_mem_data; last_rd = wb_reg_dst;
      last_m2r = wb_MemtoReg; last_rwrite = wb_RegWrite; last_excp = wb_excp;
    end else begin
      run = 0;
    end

    if (rst) begin
      done = held_valid && (!waiting || dm_ack);
      if (done) begin
        m_wb.valid  = 1'b1;
        m_wb.excp   = is_mem(held) && !is_access(held);
        m_wb.rwrite = held.rwrite && !m_wb.excp;
        m_wb.m2r    = held.m2r;
        m_wb.alu    = held.res;
        m_wb.mem    = (waiting && held.mread) ? dm_rdata : 32'h0;
        m_wb.rd     = held.rd;
      end else begin
        m_wb.valid = 1'b0;
      end
      if (ex_valid && exp_ready) begin
        cur = '{branch: ex_Branch, mread: ex_MemRead, m2r: ex_MemtoReg, mwrite: ex_MemWrite,
                rwrite: ex_RegWrite, zero: ALUZero, pc: ex_pc, res: ALUResult,
                wdata: ex_rdata2, rd: reg_dst};
        held       = cur;
        held_valid = 1'b1;
        waiting    = is_access(cur);
      end else if (done) begin
        held_valid = 1'b0;
        waiting    = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  function automatic op_t alu_op(input logic [31:0] res, input logic [4:0] rd);
    op_t o = '0;
    o.res = res; o.rd = rd; o.rwrite = 1'b1;
    return o;
  endfunction

  function automatic op_t load_op(input logic [31:0] addr, input logic [4:0] rd);
    op_t o = '0;
    o.res = addr; o.rd = rd; o.mread = 1'b1; o.m2r = 1'b1; o.rwrite = 1'b1;
    return o;
  endfunction

  function automatic op_t store_op(input logic [31:0] addr, input logic [31:0] data);
    op_t o = '0;
    o.res = addr; o.wdata = data; o.mwrite = 1'b1;
    return o;
  endfunction

  function automatic op_t br_op(input logic [31:0] pc, input logic zero);
    op_t o = '0;
    o.branch = 1'b1; o.pc = pc; o.zero = zero; o.res = zero ? 32'h0 : 32'h8;
    return o;
  endfunction

  task automatic idle(input int n);
    ex_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input op_t o, input int unsigned delay, input logic [31:0] rd);
    logic acc;
    acc = 1'b0;
    ex_Branch = o.branch; ex_MemRead = o.mread; ex_MemtoReg = o.m2r;
    ex_MemWrite = o.mwrite; ex_RegWrite = o.rwrite; ALUZero = o.zero;
    ex_pc = o.pc; ALUResult = o.res; ex_rdata2 = o.wdata; reg_dst = o.rd;
    ex_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      acc = ex_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    else if (is_access(o)) acc_q.push_back('{delay: delay, rdata: rd});
    ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    ex_Branch = 0; ex_MemRead = 0; ex_MemtoReg = 0; ex_MemWrite = 0; ex_RegWrite = 0;
    ex_pc = '0; ALUZero = 0; ALUResult = '0; ex_rdata2 = '0; reg_dst = '0;
    clear_stats();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk); #1;
    check("reset_ex_ready", ex_ready, 1'b1);
    check("reset_wb_valid", wb_valid, 1'b0);
    check("reset_wb_alu", wb_alu_result, 32'h0);
    @(posedge clk); #1;

    // Plain ALU op
    clear_stats();
    send(alu_op(32'h0000_0010, 5'd5), 0, 0);
    idle(3);
    check("alu_wb_count", n_wb, 1);
    check("alu_wb_result", last_alu, 32'h10);
    check("alu_wb_rd", last_rd, 5'd5);
    check("alu_no_req", n_req, 0);

    // Load with 3-cycle acknowledge
    clear_stats();
    send(load_op(32'h0000_0100, 5'd7), 3, 32'hDEAD_BEEF);
    idle(6);
    check("load_req_cycles", n_req, 3);
    check("load_stall_cycles", n_ready_low, 2);
    check("load_mem_data", last_mem, 32'hDEAD_BEEF);
    check("load_memtoreg", last_m2r, 1'b1);

    // Store with immediate ack, then ALU op back-to-back
    clear_stats();
    send(store_op(32'h0000_0204, 32'h0000_1234), 1, 32'hFFFF_FFFF);
    send(alu_op(32'h0000_0055, 5'd9), 0, 0);
    idle(4);
    check("store_we", last_we, 1'b1);
    check("store_wdata", last_wdata, 32'h1234);
    check("b2b_no_stall", n_ready_low, 0);
    check("b2b_wb_run", max_run, 2);
    check("b2b_last_alu", last_alu, 32'h55);

    // Taken and not-taken branches
    clear_stats();
    send(br_op(32'h0040_0080, 1'b1), 0, 0);
    idle(3);
    check("br_taken_pulse", n_pc, 1);
    check("br_target", last_target, 32'h0040_0080);
    clear_stats();
    send(br_op(32'h0040_00C0, 1'b0), 0, 0);
    idle(3);
    check("br_not_taken", n_pc, 0);

    // Misaligned load
    clear_stats();
    send(load_op(32'h0000_0103, 5'd3), 1, 32'h1111_1111);
    idle(3);
    check("misal_no_req", n_req, 0);
    check("misal_excp", last_excp, 1'b1);
    check("misal_regwrite", last_rwrite, 1'b0);

    // Stray ack outside MEM, then loads back-to-back with varying waits
    stray_ack = 1'b1;
    send(alu_op(32'h0000_0077, 5'd2), 0, 0);
    idle(2);
    stray_ack = 1'b0;
    idle(1);
    send(load_op(32'h0000_0040, 5'd4), 2, 32'hCAFE_0001);
    send(load_op(32'h0000_0044, 5'd6), 1, 32'hCAFE_0002);
    send(store_op(32'h0000_0048, 32'hA5A5_A5A5), 2, 32'h0);
    idle(6);

    // Reset during an outstanding access
    clear_stats();
    send(load_op(32'h0000_0300, 5'd8), 20, 32'h5555_5555);
    idle(2);
    #2 rst = 1'b0;
    acc_q.delete();
    #1;
    check("rst_drops_req", dm_req, 1'b0);
    check("rst_drops_wb", wb_valid, 1'b0);
    check("rst_drops_pc", pc_src, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_ready", ex_ready, 1'b1);
    check("post_rst_no_req", dm_req, 1'b0);
    @(posedge clk); #1;
    send(alu_op(32'h0000_0099, 5'd1), 0, 0);
    idle(3);
    check("post_rst_alu", last_alu, 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
